poly_crc_engine: RTL and testbench

- Parametrised bit-serial CRC/LFSR engine built from per-bit polymorphic tap cells. Each cell acts as XOR or BUF depending on a latched orientation mode, so one datapath realises two generator polynomials.
- Successor to the single-gate polymorphic test structure. Adds configurable width, two polynomials, a word-input valid/ready handshake, a shift FSM and a done pulse.
- Sits behind the polymorphic CRC APB wrapper, which drives clear, orient and the data words and reads crc_out.

---
 rtl/poly_crc_pkg.sv | 8 +
 rtl/poly_crc_if.sv | 25 ++
 rtl/poly_tap_cell.sv | 15 +
 rtl/poly_crc_engine.sv | 91 +++++++++
 tb/tb_poly_crc_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/poly_crc_pkg.sv
// Shared types and default constants for the polymorphic CRC engine.
package poly_crc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} poly_crc_state_t;

  localparam logic [31:0] DEF_POLY0 = 32'h07;
  localparam logic [31:0] DEF_POLY1 = 32'h31;
  localparam logic [31:0] DEF_SEED  = 32'h00;
endpackage

// File: rtl/poly_crc_if.sv
// Control, word handshake and status bundle between the APB wrapper and the CRC engine.
interface poly_crc_if #(
  parameter int CRC_W  = 8,
  parameter int DATA_W = 8
);
  logic              clear;
  logic              orient;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic              mode;
  logic [CRC_W-1:0]  crc_out;

  modport master (
    output clear, orient, in_valid, in_data,
    input  in_ready, busy, done, mode, crc_out
  );

  modport slave (
    input  clear, orient, in_valid, in_data,
    output in_ready, busy, done, mode, crc_out
  );
endinterface

// File: rtl/poly_tap_cell.sv
// One CRC register bit: XOR with feedback or plain buffer, picked by the latched orientation.
module poly_tap_cell #(
  parameter logic TAP0 = 1'b0,
  parameter logic TAP1 = 1'b0
) (
  input  logic shift_in,
  input  logic fb,
  input  logic orient,
  output logic next
);
  logic tap;

  assign tap  = orient ? TAP1 : TAP0;
  assign next = tap ? (shift_in ^ fb) : shift_in;
endmodule

// File: rtl/poly_crc_engine.sv
// Bit-serial CRC engine: word in via valid/ready, one bit per cycle MSB first,
// two generator polynomials sharing one row of polymorphic tap cells.
module poly_crc_engine
  import poly_crc_pkg::*;
#(
  parameter int          CRC_W  = 8,
  parameter int          DATA_W = 8,
  parameter logic [31:0] POLY0  = DEF_POLY0,
  parameter logic [31:0] POLY1  = DEF_POLY1,
  parameter logic [31:0] SEED   = DEF_SEED
) (
  input logic      CLK,
  input logic      nRST,
  poly_crc_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CRC_W-1:0] P0    = POLY0[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P1    = POLY1[CRC_W-1:0];
  localparam logic [CRC_W-1:0] SEED_W = SEED[CRC_W-1:0];

  poly_crc_state_t   state, state_nxt;
  logic [CRC_W-1:0]  crc, crc_next, shift_src;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              mode;
  logic              fb, accept, in_ready;

  // Bit 0 has no lower neighbour, so it shifts in zero.
  assign shift_src = {crc[CRC_W-2:0], 1'b0};
  assign fb        = crc[CRC_W-1] ^ sreg[DATA_W-1];

  for (genvar i = 0; i < CRC_W; i++) begin : g_tap
    poly_tap_cell #(.TAP0(P0[i]), .TAP1(P1[i])) u_tap (
      .shift_in (shift_src[i]),
      .fb       (fb),
      .orient   (mode),
      .next     (crc_next[i])
    );
  end

  assign in_ready = (state == IDLE) && !bus.clear;
  assign accept   = in_ready && bus.in_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = SHIFT;
        SHIFT:   if (cnt == '0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // clear outranks everything: a word in flight is simply dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      crc  <= SEED_W;
      mode <= 1'b0;
      cnt  <= '0;
      sreg <= '0;
    end else if (bus.clear) begin
      crc  <= SEED_W;
      mode <= bus.orient;
      cnt  <= '0;
      sreg <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        sreg <= bus.in_data;
        cnt  <= CNT_W'(DATA_W - 1);
      end
    end else if (state == SHIFT) begin
      crc  <= crc_next;
      sreg <= {sreg[DATA_W-2:0], 1'b0};
      cnt  <= cnt - 1'b1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE) && !bus.clear;
  assign bus.mode     = mode;
  assign bus.crc_out  = crc;
endmodule

// File: tb/tb_poly_crc_engine.sv
// Self-checking bench for poly_crc_engine against a polynomial-division reference model.
module tb_poly_crc_engine;
  localparam int CRC_W  = 8;
  localparam int DATA_W = 8;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] m_crc = 8'h00;
  bit         m_mode = 1'b0;

  poly_crc_if #(.CRC_W(CRC_W), .DATA_W(DATA_W)) bus ();

  poly_crc_engine #(
    .CRC_W(CRC_W), .DATA_W(DATA_W),
    .POLY0(32'h07), .POLY1(32'h31), .SEED(32'h00)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remainder of (crc ^ word) * x^8 modulo G(x) = x^8 + poly, computed over GF(2).
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d, input bit m);
    logic [15:0] v, g;
    v = {c ^ d, 8'h00};
    g = 16'h0100 | (m ? 16'h0031 : 16'h0007);
    for (int b = 15; b >= 8; b--)
      if (v[b]) v = v ^ (g << (b - 8));
    return v[7:0];
  endfunction

  task automatic do_clear(input bit o);
    @(negedge CLK);
    bus.clear = 1'b1; bus.orient = o;
    @(negedge CLK);
    bus.clear = 1'b0;
    m_crc = 8'h00; m_mode = o;
  endtask

  task automatic send_word(input logic [7:0] d, input string tag);
    int n, rdy_seen;
    @(negedge CLK);
    bus.in_valid = 1'b1; bus.in_data = d;
    n = 0;
    while (!bus.in_ready && n < 40) begin @(negedge CLK); n++; end
    if (n >= 40) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    m_crc = ref_crc(m_crc, d, m_mode);
    n = 0; rdy_seen = 0;
    while (!bus.done && n < 40) begin
      if (bus.in_ready) rdy_seen++;
      @(negedge CLK); n++;
    end
    chk({tag, "_latency"}, n, DATA_W);
    chk({tag, "_ready_low"}, rdy_seen, 0);
    chk({tag, "_crc"}, bus.crc_out, m_crc);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, low1, dones, n;
    bus.clear = 1'b0; bus.orient = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_crc", bus.crc_out, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mode", bus.mode, 0);

    // Mode 0 single words
    do_clear(1'b0);
    send_word(8'h31, "m0_31");
    chk("m0_31_const", bus.crc_out, 8'h97);
    do_clear(1'b0);
    send_word(8'h80, "m0_80");
    chk("m0_80_const", bus.crc_out, 8'h89);

    // Polymorphic switch
    do_clear(1'b0);
    send_word(8'h01, "m0_01");
    chk("m0_01_const", bus.crc_out, 8'h07);
    do_clear(1'b1);
    send_word(8'h01, "m1_01");
    chk("m1_01_const", bus.crc_out, 8'h31);
    chk("m1_mode", bus.mode, 1);
    @(negedge CLK); bus.orient = 1'b0;
    repeat (3) @(negedge CLK);
    chk("orient_no_clear", bus.mode, 1);

    // Back-to-back words with in_valid held high
    do_clear(1'b0);
    @(negedge CLK);
    bus.in_valid = 1'b1; bus.in_data = 8'h01;
    acc = 0; low1 = 0; dones = 0;
    for (int cyc = 0; cyc < 40 && dones < 2; cyc++) begin
      if (bus.done) dones++;
      if (acc == 1 && !bus.in_ready) low1++;
      if (bus.in_valid && bus.in_ready) acc++;
      @(negedge CLK);
      if (acc == 1) bus.in_data = 8'h00;
      if (acc >= 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    m_crc = ref_crc(ref_crc(8'h00, 8'h01, 1'b0), 8'h00, 1'b0);
    chk("b2b_accepts", acc, 2);
    chk("b2b_dones", dones, 2);
    chk("b2b_ready_low", low1, DATA_W + 1);
    chk("b2b_crc", bus.crc_out, m_crc);
    chk("b2b_const", bus.crc_out, 8'h15);

    // Clear in the middle of a shift
    do_clear(1'b0);
    @(negedge CLK);
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    bus.clear = 1'b1;
    @(negedge CLK);
    bus.clear = 1'b0;
    chk("midclr_crc", bus.crc_out, 0);
    chk("midclr_busy", bus.busy, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) n++;
      @(negedge CLK);
    end
    chk("midclr_no_done", n, 0);
    m_crc = 8'h00; m_mode = 1'b0;
    send_word(8'h01, "midclr_next");
    chk("midclr_next_const", bus.crc_out, 8'h07);

    // clear and in_valid together in IDLE
    @(negedge CLK);
    bus.clear = 1'b1; bus.orient = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    #1;
    chk("clrv_ready", bus.in_ready, 0);
    @(negedge CLK);
    bus.clear = 1'b0;
    #1;
    chk("clrv_not_taken", bus.busy, 0);
    chk("clrv_seed", bus.crc_out, 0);
    chk("clrv_ready_after", bus.in_ready, 1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    chk("clrv_taken", bus.busy, 1);
    m_crc = ref_crc(8'h00, 8'hA5, 1'b0); m_mode = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin @(negedge CLK); n++; end
    chk("clrv_latency", n, DATA_W);
    chk("clrv_crc", bus.crc_out, m_crc);

    // Randomised word chains with occasional clears
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(3) == 0) do_clear(1'($urandom_range(1)));
      send_word(8'($urandom), "rnd");
    end

    // Asynchronous reset in the middle of a shift
    do_clear(1'b1);
    @(negedge CLK);
    bus.in_valid = 1'b1; bus.in_data = 8'hC3;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("arst_crc", bus.crc_out, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_mode", bus.mode, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_done", bus.done, 0);
    m_crc = 8'h00; m_mode = 1'b0;
    send_word(8'h31, "arst_next");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
